// File: rtl/fp_divider_unit_if.sv
// rtl/fp_divider_unit_if.sv - request/result bundle of the FP divide unit
// Purpose: groups the operation request (start, A, B) and the result
//          (Out, busy, done) of fp_divider_unit into one interface.
// Signals:
//   start  1   operation request, sampled while the unit is idle
//   A      32  dividend, IEEE-754 single
//   B      32  divisor, IEEE-754 single
//   Out    32  registered quotient
//   busy   1   operation in flight
//   done   1   one-cycle strobe when Out is updated
// Modports: master drives the request, slave (the divider) drives the result.
interface fp_divider_unit_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Out;
  logic        busy;
  logic        done;

  modport master (output start, output A, output B,
                  input  Out,   input  busy, input done);
  modport slave  (input  start, input  A,    input B,
                  output Out,   output busy, output done);
endinterface

// File: rtl/fp_divider_unit.sv
// rtl/fp_divider_unit.sv - iterative IEEE-754 binary32 divider, Out = A / B
// Purpose: restoring mantissa divider producing one quotient bit per cycle,
//          fixed 27-cycle latency from start to done.
// Ports:
//   int_clk  in   sole clock, rising edge
//   reset    in   asynchronous active-high reset
//   bus      slave modport of fp_divider_unit_if (start/A/B in, Out/busy/done out)
// Configuration macro: FP_DIV_RNE_EN
//   defined     -> round to nearest, ties to even
//   not defined -> truncation (round toward zero)
module fp_divider_unit (
  input  logic                 int_clk,
  input  logic                 reset,
  fp_divider_unit_if.slave     bus
);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_ROUND} state_t;
  typedef enum logic [1:0] {K_NORM, K_NAN, K_INF, K_ZERO} kind_t;

  state_t             state_q;
  kind_t              kind_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [23:0]        mb_q;
  logic [24:0]        rem_q;
  logic [25:0]        q_q;
  logic [4:0]         cnt_q;
  logic [31:0]        out_q;
  logic               busy_q;
  logic               done_q;

  // ---------------- unpack / special classification ----------------
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  kind_t       kind_d;

  always_comb begin
    ea     = bus.A[30:23];
    eb     = bus.B[30:23];
    fa     = bus.A[22:0];
    fb     = bus.B[22:0];
    nan_a  = (ea == 8'hFF) && (fa != 23'd0);
    nan_b  = (eb == 8'hFF) && (fb != 23'd0);
    inf_a  = (ea == 8'hFF) && (fa == 23'd0);
    inf_b  = (eb == 8'hFF) && (fb == 23'd0);
    // A zero exponent covers both true zero and flushed denormals.
    zero_a = (ea == 8'h00);
    zero_b = (eb == 8'h00);
    kind_d = K_NORM;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b))
      kind_d = K_NAN;
    else if (inf_a || zero_b)
      kind_d = K_INF;
    else if (zero_a || inf_b)
      kind_d = K_ZERO;
  end

  // ---------------- one restoring step ----------------
  // The partial remainder stays below 2*mB, so 25 bits suffice; the shift
  // discards a top bit that is always zero after a successful subtract.
  logic        q_bit;
  logic [24:0] diff;
  logic [24:0] rem_nxt;

  always_comb begin
    q_bit   = (rem_q >= {1'b0, mb_q});
    diff    = rem_q - {1'b0, mb_q};
    rem_nxt = (q_bit ? diff : rem_q) << 1;
  end

  // ---------------- normalize / round / pack ----------------
  logic [22:0]       frac;
  logic [22:0]       frac_r;
  logic signed [9:0] e_n;
  logic signed [9:0] e_r;
  logic              inc;
  logic              carry;
  logic [31:0]       res;
`ifdef FP_DIV_RNE_EN
  logic              guard;
  logic              sticky;
`endif

  always_comb begin
    if (q_q[25]) begin
      frac = q_q[24:2];
      e_n  = exp_q;
    end else begin
      frac = q_q[23:1];
      e_n  = exp_q - 10'sd1;
    end
`ifdef FP_DIV_RNE_EN
    guard  = q_q[25] ? q_q[1] : q_q[0];
    sticky = (|rem_q) | (q_q[25] & q_q[0]);
    inc    = guard & (sticky | frac[0]);
`else
    inc    = 1'b0;
`endif
    // An all-ones fraction plus one wraps to zero, i.e. 1.0 at e+1.
    carry  = inc & (&frac);
    frac_r = frac + {22'd0, inc};
    e_r    = carry ? (e_n + 10'sd1) : e_n;

    res = 32'h00000000;
    case (kind_q)
      K_NAN:  res = 32'h7FC00000;
      K_INF:  res = {sign_q, 8'hFF, 23'd0};
      K_ZERO: res = {sign_q, 31'd0};
      default: begin
        if (e_r >= 10'sd255)
          res = {sign_q, 8'hFF, 23'd0};
        else if (e_r <= 10'sd0)
          res = {sign_q, 31'd0};
        else
          res = {sign_q, e_r[7:0], frac_r};
      end
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge int_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_NORM;
      sign_q  <= 1'b0;
      exp_q   <= 10'sd0;
      mb_q    <= 24'd0;
      rem_q   <= 25'd0;
      q_q     <= 26'd0;
      cnt_q   <= 5'd0;
      out_q   <= 32'h00000000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            kind_q  <= kind_d;
            sign_q  <= bus.A[31] ^ bus.B[31];
            exp_q   <= $signed({2'b00, ea} - {2'b00, eb} + 10'd127);
            // Hidden bit is always prepended so the divisor is never zero,
            // even for special operands whose quotient is discarded.
            mb_q    <= {1'b1, fb};
            rem_q   <= {2'b01, fa};
            q_q     <= 26'd0;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b1;
            state_q <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          q_q   <= {q_q[24:0], q_bit};
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd25)
            state_q <= S_ROUND;
        end
        S_ROUND: begin
          out_q   <= res;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.Out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_fp_divider_unit.sv
// tb/tb_fp_divider_unit.sv - self-checking bench for fp_divider_unit
module tb_fp_divider_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_divider_unit_if dif();

  fp_divider_unit dut (
    .int_clk (clk),
    .reset   (rst),
    .bus     (dif)
  );

  int checks = 0;
  int errors = 0;

  // Reference: exact rational quotient mA/mB * 2^(eA-eB), rounded using the
  // remainder of a single wide integer division.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ea, eb, e;
    longint ma, mb, num, m, r;
    logic   nan_a, nan_b, inf_a, inf_b, z_a, z_b;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    nan_a = (ea == 255) && (a[22:0] != 0);
    nan_b = (eb == 255) && (b[22:0] != 0);
    inf_a = (ea == 255) && (a[22:0] == 0);
    inf_b = (eb == 255) && (b[22:0] == 0);
    z_a   = (ea == 0);
    z_b   = (eb == 0);
    if (nan_a || nan_b || (z_a && z_b) || (inf_a && inf_b)) return 32'h7FC00000;
    if (inf_a || z_b) return {s, 8'hFF, 23'd0};
    if (z_a || inf_b) return {s, 31'd0};
    ma = longint'(a[22:0]) + (64'd1 << 23);
    mb = longint'(b[22:0]) + (64'd1 << 23);
    if (ma >= mb) begin
      num = ma << 23;
      e   = ea - eb + 127;
    end else begin
      num = ma << 24;
      e   = ea - eb + 126;
    end
    m = num / mb;
    r = num % mb;
`ifdef FP_DIV_RNE_EN
    if ((2 * r > mb) || ((2 * r == mb) && m[0])) m = m + 1;
    if (m == (64'd1 << 24)) begin
      m = 64'd1 << 23;
      e = e + 1;
    end
`else
    if (r < 0) m = 0;
`endif
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int sel;
    v   = $urandom;
    sel = $urandom_range(0, 15);
    if (sel == 0) v[30:23] = 8'h00;
    else if (sel == 1) v[30:23] = 8'hFF;
    else if (sel == 2) v[30:0] = 31'd0;
    else if (sel < 10) v[30:23] = 8'($urandom_range(100, 154));
    return v;
  endfunction

  // Issues one operation from a negedge and returns at the negedge where done
  // is high, so consecutive calls issue back to back.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output logic busy_ok);
    dif.A = a;
    dif.B = b;
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    dif.A = $urandom;
    dif.B = $urandom;
    busy_ok = (dif.busy === 1'b1);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (dif.done === 1'b1) begin
        lat = k;
        if (dif.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (dif.busy !== 1'b1) busy_ok = 1'b0;
    end
    res = dif.Out;
  endtask

  task automatic test_reset();
    dif.start = 1'b0;
    dif.A = 32'd0;
    dif.B = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dif.Out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want %h", dif.Out, 32'h0); end
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", dif.busy); end
    checks++; if (dif.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", dif.done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] va [10];
    logic [31:0] vb [10];
    logic [31:0] ve [10];
    logic [31:0] res;
    int lat;
    logic bok;
    va[0] = 32'h41000000; vb[0] = 32'h40000000; ve[0] = 32'h40800000;
    va[1] = 32'h41000000; vb[1] = 32'h3F800000; ve[1] = 32'h41000000;
    va[2] = 32'h41000000; vb[2] = 32'hC0000000; ve[2] = 32'hC0800000;
    va[3] = 32'hC15C0000; vb[3] = 32'hC0B00000; ve[3] = 32'h40200000;
    va[4] = 32'h415C0000; vb[4] = 32'hC0B00000; ve[4] = 32'hC0200000;
`ifdef FP_DIV_RNE_EN
    va[5] = 32'h3F800000; vb[5] = 32'h40400000; ve[5] = 32'h3EAAAAAB;
`else
    va[5] = 32'h3F800000; vb[5] = 32'h40400000; ve[5] = 32'h3EAAAAAA;
`endif
    va[6] = 32'h40A00000; vb[6] = 32'h00000000; ve[6] = 32'h7F800000;
    va[7] = 32'h00000000; vb[7] = 32'h00000000; ve[7] = 32'h7FC00000;
    va[8] = 32'h7F000000; vb[8] = 32'h00800000; ve[8] = 32'h7F800000;
    va[9] = 32'h00800000; vb[9] = 32'h7F000000; ve[9] = 32'h00000000;
    for (int i = 0; i < 10; i++) begin
      do_op(va[i], vb[i], res, lat, bok);
      checks++; if (res !== ve[i]) begin errors++; $display("FAIL directed_out[%0d]: got %h want %h", i, res, ve[i]); end
      checks++; if (lat != 27) begin errors++; $display("FAIL directed_latency[%0d]: got %0d want 27", i, lat); end
      checks++; if (!bok) begin errors++; $display("FAIL directed_busy[%0d]: busy profile wrong", i); end
    end
    @(negedge clk);
    checks++; if (dif.done !== 1'b0) begin errors++; $display("FAIL done_single_pulse: got %b want 0", dif.done); end
    checks++; if (dif.Out !== ve[9]) begin errors++; $display("FAIL out_hold: got %h want %h", dif.Out, ve[9]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, res, exp_v;
    int lat;
    logic bok;
    for (int i = 0; i < 200; i++) begin
      a = rnd_op();
      b = rnd_op();
      exp_v = ref_div(a, b);
      do_op(a, b, res, lat, bok);
      checks++; if (res !== exp_v) begin errors++; $display("FAIL random_out[%0d]: %h/%h got %h want %h", i, a, b, res, exp_v); end
      checks++; if (lat != 27 || !bok) begin errors++; $display("FAIL random_timing[%0d]: latency %0d busy_ok %b want 27 1", i, lat, bok); end
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    logic [31:0] prev;
    int ndone;
    prev = dif.Out;
    dif.A = 32'h41000000;
    dif.B = 32'h3F800000;
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) begin
        dif.A = 32'h3F800000;
        dif.B = 32'h40400000;
        dif.start = 1'b1;
      end
      @(negedge clk);
      dif.start = 1'b0;
      if (dif.done === 1'b1) ndone++;
      if (k == 12) begin
        checks++; if (dif.Out !== prev) begin errors++; $display("FAIL busy_out_stable: got %h want %h", dif.Out, prev); end
      end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignored_start_done_count: got %0d want 1", ndone); end
    checks++; if (dif.Out !== 32'h41000000) begin errors++; $display("FAIL ignored_start_out: got %h want %h", dif.Out, 32'h41000000); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    dif.A = 32'h41000000;
    dif.B = 32'h40000000;
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (dif.busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b want 1", dif.busy); end
    rst = 1'b1;
    #1;
    checks++; if (dif.Out !== 32'h0) begin errors++; $display("FAIL midreset_out: got %h want 0", dif.Out); end
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", dif.busy); end
    checks++; if (dif.done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", dif.done); end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dif.done === 1'b1 || dif.busy === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL post_reset_activity: got %0d cycles want 0", ndone); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_divider_unit.md
# fp_divider_unit

Iterative IEEE-754 single-precision floating-point divider computing Out = A / B. Runs on the integer-pipeline clock and takes one `start` pulse per operation. It produces one quotient bit per cycle through a restoring mantissa divider and returns a fixed-latency result with a `done` strobe. It serves as the FP divide execution unit beside the integer datapath.

## Interface
- No parameters; the format is fixed at binary32.
- `int_clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  operation request; sampled on a rising edge while idle.
- `A`  in  32  dividend, IEEE-754 single.
- `B`  in  32  divisor, IEEE-754 single.
- `Out`  out  32  registered quotient; holds the last result until the next `done`.
- `busy`  out  1  high from the edge after `start` is accepted until the edge on which `done` rises.
- `done`  out  1  one-cycle pulse when `Out` is updated.

## Operation
- Reset values: `Out`=32'h00000000, `busy`=0, `done`=0, state IDLE, all internal registers cleared.
- States and transitions:
  - IDLE → DIVIDE on `start`. The edge captures A and B, unpacks them, and sets `busy`.
  - DIVIDE: 26 cycles, one quotient bit per cycle.
  - ROUND: 1 cycle to normalize, round, pack, and write `Out`. `done` pulses and `busy` drops. Then → IDLE.
- `start` while busy is ignored. A and B may change after capture without affecting the operation.
- Unpack rules:
  - Sign = sA ^ sB.
  - Mantissas get the hidden 1 prepended (24 bits).
  - Exponent difference e = eA − eB + 127, held as a signed 10-bit value.
- Divide:
  - Restoring division of mA·2^25 by mB gives 26-bit q, with q in [2^24, 2^26), plus a remainder.
  - Sticky bit = (remainder ≠ 0).
- Normalize:
  - If q[25]=1: mantissa = q[25:2], guard = q[1], sticky |= q[0].
  - Else: mantissa = q[24:1], guard = q[0], and e decrements by 1.
- Round: per Configuration. A carry out of the mantissa renormalizes it to 1.0 and increments e.
- Pack:
  - e ≥ 255 → signed infinity.
  - e ≤ 0 → signed zero (no denormal output).
  - Otherwise {sign, e[7:0], mantissa[22:0]}.
- Special operands:
  - Denormal inputs are flushed to zero; their sign is kept.
  - Special cases are resolved at unpack but still take the full latency.
  - NaN on either input → 32'h7FC00000.
  - 0/0 and ∞/∞ → 32'h7FC00000.
  - x/0 with x ≠ 0 → signed ∞.
  - ∞/x with x finite → signed ∞.
  - 0/x and x/∞ → signed zero.
- `reset` asserted mid-operation aborts the operation immediately; all outputs return to their reset values.

## Timing
- Latency: `start` sampled at edge 0; `done`=1 and the new `Out` are visible after edge 27 (27 cycles).
- `busy` is high after edges 0 through 26.
- Back-to-back issue: a new `start` may be asserted in the cycle `done` is high. It is accepted at the next edge, giving a throughput of one result per 28 cycles.
- `Out` changes only on the `done` edge or on reset.

## Configuration
- `FP_DIV_RNE_EN` defined: round-to-nearest-even. The mantissa increments when guard & (sticky | mantissa[0]).
- Not defined: truncation (round toward zero); guard and sticky are discarded.
- Exact quotients are identical in both builds.

## Test plan
- 8/2: A=32'h41000000, B=32'h40000000 → Out=32'h40800000 and `done` one pulse after 27 cycles. Repeat with 8/1 (B=32'h3F800000) → 32'h41000000.
- Signs: 32'h41000000/32'hC0000000 → 32'hC0800000. 32'hC15C0000/32'hC0B00000 → 32'h40200000. 32'h415C0000/32'hC0B00000 → 32'hC0200000.
- Rounding: 1/3 (32'h3F800000/32'h40400000) → 32'h3EAAAAAB with `FP_DIV_RNE_EN`, 32'h3EAAAAAA without.
- Specials:
  - 5/0 (32'h40A00000/32'h00000000) → 32'h7F800000.
  - 0/0 → 32'h7FC00000.
  - 32'h7F000000/32'h00800000 → 32'h7F800000 (overflow).
- Control: a `start` pulse during `busy` is ignored, `Out` is unchanged, and there is a single `done`. Asserting `reset` at cycle 10 gives `Out`=0, `busy`=0, `done`=0, and no `done` pulse afterwards.
